// File: rtl/uart_duplex_core_if.sv
// Bundle of configuration, transmit and receive signals for uart_duplex_core.
// master: the side that configures the UART and exchanges data with it.
// slave:  the UART core itself.
interface uart_duplex_core_if #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned PRESCALE_WIDTH = 6,
   parameter int unsigned DIV_WIDTH      = 12
);
   logic [DIV_WIDTH-1:0]      baud_div;
   logic [PRESCALE_WIDTH-1:0] prescale;
   logic                      par_en;
   logic                      par_typ;
   logic                      stop2;
   logic [DATA_WIDTH-1:0]     tx_in;
   logic                      tx_data_vld;
   logic                      tx_out;
   logic                      tx_busy;
   logic                      rx_in;
   logic [DATA_WIDTH-1:0]     rx_out;
   logic                      rx_data_vld;
   logic                      par_err;
   logic                      frm_err;
   logic                      brk_det;

   modport master (
      output baud_div, prescale, par_en, par_typ, stop2, tx_in, tx_data_vld, rx_in,
      input  tx_out, tx_busy, rx_out, rx_data_vld, par_err, frm_err, brk_det
   );

   modport slave (
      input  baud_div, prescale, par_en, par_typ, stop2, tx_in, tx_data_vld, rx_in,
      output tx_out, tx_busy, rx_out, rx_data_vld, par_err, frm_err, brk_det
   );
endinterface

// File: rtl/uart_duplex_core.sv
// Full-duplex UART core: independent transmitter and receiver sharing one clock.
// Bit time is PRESCALE*(BAUD_DIV+1) clocks; the receiver majority-votes three
// samples around the middle of each bit.
// Optional feature macro: UART_BREAK_DET_EN (break detection on brk_det).
module uart_duplex_core #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned PRESCALE_WIDTH = 6,
   parameter int unsigned DIV_WIDTH      = 12
) (
   input logic              clk,
   input logic              rst,
   uart_duplex_core_if.slave bus
);

   localparam int unsigned IdxW = $clog2(DATA_WIDTH);
   localparam logic [IdxW-1:0]           IdxLast = IdxW'(DATA_WIDTH - 1);
   localparam logic [IdxW-1:0]           IdxOne  = IdxW'(1);
   localparam logic [PRESCALE_WIDTH-1:0] PreMin  = PRESCALE_WIDTH'(4);
   localparam logic [PRESCALE_WIDTH-1:0] PreOne  = PRESCALE_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0]      DivOne  = DIV_WIDTH'(1);

   typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxBreak} rx_state_e;

   logic [PRESCALE_WIDTH-1:0] pre_eff;
   assign pre_eff = (bus.prescale < PreMin) ? PreMin : bus.prescale;

   // ---------------------------------------------------------------- transmitter
   tx_state_e                 tx_state_q;
   logic [DIV_WIDTH-1:0]      tx_div_cnt_q, tx_div_q;
   logic [PRESCALE_WIDTH-1:0] tx_tick_cnt_q, tx_pre_q;
   logic [DATA_WIDTH-1:0]     tx_shift_q;
   logic [IdxW-1:0]           tx_idx_q;
   logic                      tx_par_en_q, tx_par_bit_q, tx_stop2_q, tx_stop_cnt_q;
   logic                      tx_out_q, tx_busy_q;
   logic                      tx_bit_end;

   assign tx_bit_end = (tx_div_cnt_q == tx_div_q) && (tx_tick_cnt_q == tx_pre_q - PreOne);

   // Transmit FSM: bit timing counters plus registered line and busy outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q    <= TxIdle;
         tx_div_cnt_q  <= '0;
         tx_div_q      <= '0;
         tx_tick_cnt_q <= '0;
         tx_pre_q      <= PreMin;
         tx_shift_q    <= '0;
         tx_idx_q      <= '0;
         tx_par_en_q   <= 1'b0;
         tx_par_bit_q  <= 1'b0;
         tx_stop2_q    <= 1'b0;
         tx_stop_cnt_q <= 1'b0;
         tx_out_q      <= 1'b1;
         tx_busy_q     <= 1'b0;
      end else begin
         if (tx_state_q != TxIdle) begin
            if (tx_div_cnt_q == tx_div_q) begin
               tx_div_cnt_q <= '0;
               if (tx_tick_cnt_q == tx_pre_q - PreOne) tx_tick_cnt_q <= '0;
               else                                    tx_tick_cnt_q <= tx_tick_cnt_q + PreOne;
            end else begin
               tx_div_cnt_q <= tx_div_cnt_q + DivOne;
            end
         end
         unique case (tx_state_q)
            TxIdle: begin
               if (bus.tx_data_vld) begin
                  // Frame settings are frozen here for the whole frame.
                  tx_shift_q    <= bus.tx_in;
                  tx_par_bit_q  <= (^bus.tx_in) ^ bus.par_typ;
                  tx_par_en_q   <= bus.par_en;
                  tx_stop2_q    <= bus.stop2;
                  tx_pre_q      <= pre_eff;
                  tx_div_q      <= bus.baud_div;
                  tx_div_cnt_q  <= '0;
                  tx_tick_cnt_q <= '0;
                  tx_idx_q      <= '0;
                  tx_stop_cnt_q <= 1'b0;
                  tx_out_q      <= 1'b0;
                  tx_busy_q     <= 1'b1;
                  tx_state_q    <= TxStart;
               end
            end
            TxStart: begin
               if (tx_bit_end) begin
                  tx_out_q   <= tx_shift_q[0];
                  tx_state_q <= TxData;
               end
            end
            TxData: begin
               if (tx_bit_end) begin
                  if (tx_idx_q == IdxLast) begin
                     if (tx_par_en_q) begin
                        tx_out_q   <= tx_par_bit_q;
                        tx_state_q <= TxParity;
                     end else begin
                        tx_out_q   <= 1'b1;
                        tx_state_q <= TxStop;
                     end
                  end else begin
                     tx_out_q   <= tx_shift_q[1];
                     tx_shift_q <= tx_shift_q >> 1;
                     tx_idx_q   <= tx_idx_q + IdxOne;
                  end
               end
            end
            TxParity: begin
               if (tx_bit_end) begin
                  tx_out_q   <= 1'b1;
                  tx_state_q <= TxStop;
               end
            end
            TxStop: begin
               if (tx_bit_end) begin
                  if (tx_stop2_q && !tx_stop_cnt_q) begin
                     tx_stop_cnt_q <= 1'b1;
                  end else begin
                     tx_busy_q  <= 1'b0;
                     tx_state_q <= TxIdle;
                  end
               end
            end
            default: tx_state_q <= TxIdle;
         endcase
      end
   end

   assign bus.tx_out  = tx_out_q;
   assign bus.tx_busy = tx_busy_q;

   // ------------------------------------------------------------------- receiver
   logic                      rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_e                 rx_state_q;
   logic [DIV_WIDTH-1:0]      rx_div_cnt_q, rx_div_q;
   logic [PRESCALE_WIDTH-1:0] rx_tick_cnt_q, rx_pre_q, rx_mid;
   logic [DATA_WIDTH-1:0]     rx_shift_q, rx_out_q;
   logic [IdxW-1:0]           rx_idx_q;
   logic                      rx_par_en_q, rx_par_typ_q, rx_par_bit_q;
   logic [1:0]                rx_ones_q;
   logic                      rx_data_vld_q, par_err_q, frm_err_q;
   logic                      rx_tick, rx_sample, rx_vote_now, rx_vote, rx_bit_end, rx_par_bad;

   assign rx_mid      = rx_pre_q >> 1;
   assign rx_tick     = (rx_div_cnt_q == rx_div_q);
   assign rx_sample   = rx_tick && ((rx_tick_cnt_q == rx_mid - PreOne) || (rx_tick_cnt_q == rx_mid));
   assign rx_vote_now = rx_tick && (rx_tick_cnt_q == rx_mid + PreOne);
   // Two earlier samples are counted in rx_ones_q; the third is the live line.
   assign rx_vote     = rx_ones_q[1] | (rx_ones_q[0] & rx_sync_q);
   assign rx_bit_end  = rx_tick && (rx_tick_cnt_q == rx_pre_q - PreOne);
   assign rx_par_bad  = rx_par_en_q && (((^rx_shift_q) ^ rx_par_typ_q) != rx_par_bit_q);

`ifdef UART_BREAK_DET_EN
   logic brk_det_q, rx_break;
   assign rx_break = !rx_vote && (rx_shift_q == '0) && !(rx_par_en_q && rx_par_bit_q);
`endif

   // Two-flop synchroniser plus one history flop for falling-edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= bus.rx_in;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   // Receive FSM: bit timing, majority voting and registered status pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_q    <= RxIdle;
         rx_div_cnt_q  <= '0;
         rx_div_q      <= '0;
         rx_tick_cnt_q <= '0;
         rx_pre_q      <= PreMin;
         rx_shift_q    <= '0;
         rx_out_q      <= '0;
         rx_idx_q      <= '0;
         rx_par_en_q   <= 1'b0;
         rx_par_typ_q  <= 1'b0;
         rx_par_bit_q  <= 1'b0;
         rx_ones_q     <= '0;
         rx_data_vld_q <= 1'b0;
         par_err_q     <= 1'b0;
         frm_err_q     <= 1'b0;
`ifdef UART_BREAK_DET_EN
         brk_det_q     <= 1'b0;
`endif
      end else begin
         rx_data_vld_q <= 1'b0;
         par_err_q     <= 1'b0;
         frm_err_q     <= 1'b0;
`ifdef UART_BREAK_DET_EN
         brk_det_q     <= 1'b0;
`endif
         if (rx_state_q != RxIdle) begin
            if (rx_tick) begin
               rx_div_cnt_q <= '0;
               if (rx_tick_cnt_q == rx_pre_q - PreOne) rx_tick_cnt_q <= '0;
               else                                    rx_tick_cnt_q <= rx_tick_cnt_q + PreOne;
            end else begin
               rx_div_cnt_q <= rx_div_cnt_q + DivOne;
            end
            if (rx_sample && rx_sync_q) rx_ones_q <= rx_ones_q + 2'd1;
            else if (rx_vote_now)       rx_ones_q <= '0;
         end
         unique case (rx_state_q)
            RxIdle: begin
               if (rx_prev_q && !rx_sync_q) begin
                  rx_par_en_q   <= bus.par_en;
                  rx_par_typ_q  <= bus.par_typ;
                  rx_pre_q      <= pre_eff;
                  rx_div_q      <= bus.baud_div;
                  rx_div_cnt_q  <= '0;
                  rx_tick_cnt_q <= '0;
                  rx_ones_q     <= '0;
                  rx_idx_q      <= '0;
                  rx_state_q    <= RxStart;
               end
            end
            RxStart: begin
               if (rx_vote_now && rx_vote) rx_state_q <= RxIdle;  // glitch, not a start bit
               else if (rx_bit_end)        rx_state_q <= RxData;
            end
            RxData: begin
               if (rx_vote_now) rx_shift_q <= {rx_vote, rx_shift_q[DATA_WIDTH-1:1]};
               if (rx_bit_end) begin
                  if (rx_idx_q == IdxLast) rx_state_q <= rx_par_en_q ? RxParity : RxStop;
                  else                     rx_idx_q   <= rx_idx_q + IdxOne;
               end
            end
            RxParity: begin
               if (rx_vote_now) rx_par_bit_q <= rx_vote;
               if (rx_bit_end)  rx_state_q   <= RxStop;
            end
            RxStop: begin
               // Only the first stop bit is judged; anything after it is idle line.
               if (rx_vote_now) begin
                  par_err_q <= rx_par_bad;
                  frm_err_q <= !rx_vote;
                  if (!rx_par_bad && rx_vote) begin
                     rx_out_q      <= rx_shift_q;
                     rx_data_vld_q <= 1'b1;
                  end
`ifdef UART_BREAK_DET_EN
                  if (rx_break) begin
                     brk_det_q     <= 1'b1;
                     rx_div_cnt_q  <= '0;
                     rx_tick_cnt_q <= '0;
                     rx_state_q    <= RxBreak;
                  end else begin
                     rx_state_q <= RxIdle;
                  end
`else
                  rx_state_q <= RxIdle;
`endif
               end
            end
`ifdef UART_BREAK_DET_EN
            RxBreak: begin
               // Need one unbroken bit time of high line before listening again.
               if (!rx_sync_q) begin
                  rx_div_cnt_q  <= '0;
                  rx_tick_cnt_q <= '0;
               end else if (rx_bit_end) begin
                  rx_state_q <= RxIdle;
               end
            end
`endif
            default: rx_state_q <= RxIdle;
         endcase
      end
   end

   assign bus.rx_out      = rx_out_q;
   assign bus.rx_data_vld = rx_data_vld_q;
   assign bus.par_err     = par_err_q;
   assign bus.frm_err     = frm_err_q;
`ifdef UART_BREAK_DET_EN
   assign bus.brk_det     = brk_det_q;
`else
   assign bus.brk_det     = 1'b0;
`endif

endmodule

// File: doc/uart_duplex_core.md
UART_DUPLEX_CORE -- requirements
Module: uart_duplex_core

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter PRESCALE_WIDTH, default 6, width of the PRESCALE oversampling-ratio port.
REQ-003 Parameter DIV_WIDTH, default 12, width of the BAUD_DIV clock-divider port.
REQ-004 CLK  input  1  single clock for the whole block; all logic on the rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 BAUD_DIV  input  DIV_WIDTH  oversample tick every BAUD_DIV+1 CLK cycles.
REQ-007 PRESCALE  input  PRESCALE_WIDTH  ticks per bit; values below 4 are treated as 4.
REQ-008 PAR_EN  input  1  parity bit present in frame.
REQ-009 PAR_TYP  input  1  0 selects even parity, 1 selects odd parity.
REQ-010 STOP2  input  1  0 selects one stop bit, 1 selects two stop bits.
REQ-011 TX_IN  input  DATA_WIDTH  parallel transmit data.
REQ-012 TX_DATA_VLD  input  1  transmit request.
REQ-013 TX_OUT  output  1  serial transmit line, idle high.
REQ-014 TX_BUSY  output  1  transmitter is sending a frame.
REQ-015 RX_IN  input  1  asynchronous serial receive line.
REQ-016 RX_OUT  output  DATA_WIDTH  last good received word.
REQ-017 RX_DATA_VLD, PAR_ERR, FRM_ERR, BRK_DET  output  1 each  one-cycle status pulses.

Function
REQ-018 TX and RX each SHALL own a divider counter 0..BAUD_DIV, restarted at frame start; bit time = PRESCALE*(BAUD_DIV+1) CLK cycles.
REQ-019 PAR_EN, PAR_TYP, STOP2, PRESCALE and BAUD_DIV SHALL be captured at frame start; changes mid-frame are ignored until the next frame.
REQ-020 TX FSM: IDLE -> START -> DATA (LSB first, DATA_WIDTH bits) -> PARITY (only if PAR_EN) -> STOP (1 or 2 bits) -> IDLE.
REQ-021 TX SHALL accept TX_IN when TX_DATA_VLD=1 and TX_BUSY=0; TX_BUSY and the start bit (TX_OUT=0) assert on the next CLK edge.
REQ-022 TX_DATA_VLD while TX_BUSY=1 SHALL be ignored and the data dropped.
REQ-023 TX_BUSY SHALL deassert on the cycle after the last stop bit ends; back-to-back acceptance on that cycle is allowed.
REQ-024 Parity SHALL be the XOR of the data bits, inverted when PAR_TYP=1.
REQ-025 RX_IN SHALL pass through a 2-flop synchroniser before any use.
REQ-026 RX FSM: IDLE -> START -> DATA -> PARITY (if PAR_EN) -> STOP -> IDLE; a high-to-low transition in IDLE starts a frame.
REQ-027 Each bit SHALL be decided by majority vote of three samples at ticks PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1 (integer division).
REQ-028 A start bit voting 1 SHALL be a glitch: return to IDLE with no pulses.
REQ-029 RX SHALL evaluate only the first stop bit and return to IDLE immediately after its vote; a second stop bit is treated as idle line.
REQ-030 At the stop vote: good frame -> RX_OUT updated and RX_DATA_VLD pulses once; parity mismatch -> PAR_ERR pulses; stop bit 0 -> FRM_ERR pulses.
REQ-031 On any error RX_DATA_VLD SHALL stay 0 and RX_OUT SHALL hold its previous value; PAR_ERR and FRM_ERR may pulse in the same cycle.
REQ-032 TX and RX SHALL be fully independent; simultaneous activity is legal.

Reset
REQ-033 RST=1 at a CLK edge SHALL force both FSMs to IDLE and clear the counters and the synchroniser (to 1), including mid-frame.
REQ-034 Reset values: TX_OUT=1, TX_BUSY=0, RX_OUT=0, RX_DATA_VLD=0, PAR_ERR=0, FRM_ERR=0, BRK_DET=0.
REQ-035 A frame interrupted by reset SHALL be abandoned with no status pulse.

Configuration
REQ-036 Macro UART_BREAK_DET_EN SHALL compile in break detection.
REQ-037 Break condition: all data bits 0, parity bit 0 if present, and stop bit 0.
REQ-038 With UART_BREAK_DET_EN defined, a break SHALL pulse BRK_DET together with FRM_ERR.
REQ-039 With UART_BREAK_DET_EN defined, after a break RX SHALL wait for RX_IN high for one full bit time before re-entering IDLE.
REQ-040 Without UART_BREAK_DET_EN, the BRK_DET port SHALL exist, be tied to 0, and RX SHALL return to IDLE immediately after the stop vote.

Verification
REQ-041 RST high for 2 cycles mid-TX-frame -> the next cycle shows TX_OUT=1, TX_BUSY=0, and all pulses 0.
REQ-042 BAUD_DIV=0, PRESCALE=8, PAR_EN=1, PAR_TYP=0, STOP2=0, TX_IN=0xA5 -> TX_OUT bit sequence 0,1,0,1,0,0,1,0,1,0,1 at 8 cycles per bit, with TX_BUSY high for 88 cycles.
REQ-043 TX_OUT looped to RX_IN with TX_IN=0x3C, PAR_TYP=1, STOP2=1, BAUD_DIV=3, PRESCALE=16 -> exactly one RX_DATA_VLD pulse, RX_OUT=0x3C, and no errors.
REQ-044 Inject an 0x55 frame with an inverted parity bit -> PAR_ERR pulses once, RX_DATA_VLD=0, and RX_OUT unchanged.
REQ-045 PRESCALE=16 with RX_IN low for 2 cycles only -> no pulses, and RX back in IDLE.
REQ-046 RX_IN low for 12 bit times -> with the macro defined, FRM_ERR and BRK_DET pulse once each; without the macro, FRM_ERR pulses and BRK_DET stays 0.
